// File: rtl/pll_lock_detector.sv
// PLL lock detector.
// Watches the bang-bang phase detector direction bit and the loop-filter
// control word over fixed windows. A window is "good" when the control word
// stays inside a narrow band and the phase error dithers enough. Consecutive
// good windows declare lock, and consecutive bad windows while locked declare
// loss of lock.
//
// Interface timing:
//   There is no valid/ready handshake. Every enabled clk cycle is one sample.
//   window_done and lock_lost are single-cycle pulses. They are raised only
//   on the edge that closes a window. locked and lock_state are registered
//   and change on that same edge.
module pll_lock_detector #(
  parameter int CTRL_WIDTH     = 20,
  parameter int WINDOW_CYCLES  = 256,
  parameter int TOL            = 64,
  parameter int MIN_TOGGLES    = 4,
  parameter int LOCK_WINDOWS   = 8,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  phase_error,
  input  logic [CTRL_WIDTH-1:0] dig_ctrl_voltage,
  output logic                  locked,
  output logic [1:0]            lock_state,
  output logic                  lock_lost,
  output logic                  window_done,
  output logic [CTRL_WIDTH-1:0] window_span
);

  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int TW = WW + 1;
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int BW = $clog2(UNLOCK_WINDOWS + 1);

  localparam logic [WW-1:0]         WLAST   = WW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0]         TSAT    = '1;
  localparam logic [GW-1:0]         GTARGET = GW'(LOCK_WINDOWS);
  localparam logic [BW-1:0]         BTARGET = BW'(UNLOCK_WINDOWS);
  localparam logic [CTRL_WIDTH-1:0] TOL_W   = CTRL_WIDTH'(TOL);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  state_t                  state;
  logic [WW-1:0]           wcnt;
  logic [CTRL_WIDTH-1:0]   trk_min;
  logic [CTRL_WIDTH-1:0]   trk_max;
  logic [TW-1:0]           tog_cnt;
  logic                    prev_pe;
  logic                    prev_valid;
  logic [GW-1:0]           good_cnt;
  logic [BW-1:0]           bad_cnt;

  logic                    win_start;
  logic                    win_end;
  logic                    toggle;
  logic [CTRL_WIDTH-1:0]   base_min;
  logic [CTRL_WIDTH-1:0]   base_max;
  logic [CTRL_WIDTH-1:0]   cur_min;
  logic [CTRL_WIDTH-1:0]   cur_max;
  logic [CTRL_WIDTH-1:0]   cur_span;
  logic [TW-1:0]           tog_base;
  logic [TW-1:0]           cur_tog;
  logic                    win_good;

  state_t                  state_nx;
  logic [GW-1:0]           good_nx;
  logic [BW-1:0]           bad_nx;
  logic                    lost_nx;

  // Fold the current sample and transition into this window's running
  // statistics. At the first cycle of a window the trackers restart, so the
  // previous window's values are ignored.
  always_comb begin
    win_start = (wcnt == '0);
    win_end   = (wcnt == WLAST);
    toggle    = prev_valid && (phase_error != prev_pe);
    base_min  = win_start ? dig_ctrl_voltage : trk_min;
    base_max  = win_start ? dig_ctrl_voltage : trk_max;
    cur_min   = (dig_ctrl_voltage < base_min) ? dig_ctrl_voltage : base_min;
    cur_max   = (dig_ctrl_voltage > base_max) ? dig_ctrl_voltage : base_max;
    cur_span  = cur_max - cur_min;
    tog_base  = win_start ? '0 : tog_cnt;
    cur_tog   = (toggle && (tog_base != TSAT)) ? tog_base + TW'(1) : tog_base;
    win_good  = (cur_span <= TOL_W) && (32'(cur_tog) >= 32'(MIN_TOGGLES));
  end

  // Lock FSM next-state. It advances only on the edge that closes a window,
  // except for the illegal encoding, which is recovered immediately.
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    lost_nx  = 1'b0;
    if (win_end) begin
      case (state)
        ST_UNLOCKED: begin
          if (win_good) begin
            good_nx  = GW'(1);
            state_nx = (LOCK_WINDOWS == 1) ? ST_LOCKED : ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (win_good) begin
            good_nx = good_cnt + GW'(1);
            if (good_nx >= GTARGET) begin
              state_nx = ST_LOCKED;
              bad_nx   = '0;
            end
          end else begin
            state_nx = ST_UNLOCKED;
            good_nx  = '0;
          end
        end
        ST_LOCKED: begin
          if (!win_good) begin
            bad_nx = bad_cnt + BW'(1);
            if (bad_nx >= BTARGET) begin
              state_nx = ST_UNLOCKED;
              lost_nx  = 1'b1;
              good_nx  = '0;
              bad_nx   = '0;
            end
          end else begin
            bad_nx = '0;
          end
        end
        default: state_nx = ST_UNLOCKED;
      endcase
    end else if (state == ST_ILLEGAL) begin
      state_nx = ST_UNLOCKED;
    end
  end

  // Window counter, trackers, FSM and registered outputs. Dropping enable
  // clears everything except the last reported span, so a disabled detector
  // restarts from a full fresh window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_UNLOCKED;
      wcnt        <= '0;
      trk_min     <= '0;
      trk_max     <= '0;
      tog_cnt     <= '0;
      prev_pe     <= 1'b0;
      prev_valid  <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      locked      <= 1'b0;
      lock_state  <= 2'd0;
      lock_lost   <= 1'b0;
      window_done <= 1'b0;
      window_span <= '0;
    end else if (!enable) begin
      state       <= ST_UNLOCKED;
      wcnt        <= '0;
      trk_min     <= '0;
      trk_max     <= '0;
      tog_cnt     <= '0;
      prev_pe     <= 1'b0;
      prev_valid  <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      locked      <= 1'b0;
      lock_state  <= 2'd0;
      lock_lost   <= 1'b0;
      window_done <= 1'b0;
    end else begin
      wcnt        <= win_end ? '0 : wcnt + WW'(1);
      trk_min     <= cur_min;
      trk_max     <= cur_max;
      tog_cnt     <= cur_tog;
      prev_pe     <= phase_error;
      prev_valid  <= 1'b1;
      state       <= state_nx;
      good_cnt    <= good_nx;
      bad_cnt     <= bad_nx;
      locked      <= (state_nx == ST_LOCKED);
      lock_state  <= state_nx;
      lock_lost   <= lost_nx;
      window_done <= win_end;
      if (win_end) begin
        window_span <= cur_span;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Testbench for pll_lock_detector: directed scenario sequence with randomized
// control-word and phase-error content, checked every cycle against a
// window-level behavioural model.
module tb_pll_lock_detector;

  localparam int CW     = 20;
  localparam int WIN    = 256;
  localparam int TOL    = 64;
  localparam int MIN_T  = 4;
  localparam int LOCK_W = 8;
  localparam int ULCK_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          phase_error;
  logic [CW-1:0] dig_ctrl_voltage;
  logic          locked;
  logic [1:0]    lock_state;
  logic          lock_lost;
  logic          window_done;
  logic [CW-1:0] window_span;

  int n_tests;
  int n_fail;

  // Reference model: samples of the open window and the lock bookkeeping.
  logic [CW-1:0] win_q[$];
  int            m_tog;
  logic          m_prev;
  bit            m_prev_valid;
  int            m_state;
  int            m_good;
  int            m_bad;
  logic          m_lost;
  logic          m_done;
  logic [CW-1:0] m_span;
  logic          cur_pe;

  pll_lock_detector #(
    .CTRL_WIDTH(CW), .WINDOW_CYCLES(WIN), .TOL(TOL), .MIN_TOGGLES(MIN_T),
    .LOCK_WINDOWS(LOCK_W), .UNLOCK_WINDOWS(ULCK_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_error(phase_error),
    .dig_ctrl_voltage(dig_ctrl_voltage), .locked(locked),
    .lock_state(lock_state), .lock_lost(lock_lost),
    .window_done(window_done), .window_span(window_span)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit keep_span);
    win_q.delete();
    m_tog = 0;
    m_prev = 1'b0;
    m_prev_valid = 1'b0;
    m_state = 0;
    m_good = 0;
    m_bad = 0;
    if (!keep_span) m_span = '0;
  endtask

  // One clk edge of the model: a window closes when WIN enabled samples
  // have been gathered; its verdict drives the good/bad window bookkeeping.
  task automatic model_edge(input logic r, input logic en, input logic pe, input logic [CW-1:0] cv);
    logic [CW-1:0] mn, mx;
    bit good;
    m_lost = 1'b0;
    m_done = 1'b0;
    if (r) begin
      model_clear(1'b0);
    end else if (!en) begin
      model_clear(1'b1);
    end else begin
      if (win_q.size() == 0) m_tog = 0;
      if (m_prev_valid && (pe != m_prev)) m_tog++;
      m_prev = pe;
      m_prev_valid = 1'b1;
      win_q.push_back(cv);
      if (win_q.size() == WIN) begin
        mn = win_q[0];
        mx = win_q[0];
        foreach (win_q[k]) begin
          if (win_q[k] < mn) mn = win_q[k];
          if (win_q[k] > mx) mx = win_q[k];
        end
        good = ((mx - mn) <= CW'(TOL)) && (m_tog >= MIN_T);
        m_span = mx - mn;
        m_done = 1'b1;
        win_q.delete();
        if (m_state == 2) begin
          if (good) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad >= ULCK_W) begin
              m_state = 0; m_lost = 1'b1; m_good = 0; m_bad = 0;
            end
          end
        end else if (good) begin
          m_good = (m_state == 0) ? 1 : m_good + 1;
          if (m_good >= LOCK_W) begin m_state = 2; m_bad = 0; end
          else m_state = 1;
        end else begin
          m_state = 0; m_good = 0;
        end
      end
    end
  endtask

  // Driver: apply inputs, take one edge, then compare all outputs 1 ns later.
  task automatic step(input logic r, input logic en, input logic pe, input logic [CW-1:0] cv);
    rst = r;
    enable = en;
    phase_error = pe;
    dig_ctrl_voltage = cv;
    @(posedge clk);
    model_edge(r, en, pe, cv);
    #1;
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("lock_state", 32'(lock_state), 32'(m_state));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("window_done", 32'(window_done), 32'(m_done));
    chk("window_span", 32'(window_span), 32'(m_span));
  endtask

  task automatic good_window();
    logic [CW-1:0] base;
    base = CW'($urandom_range(0, (1 << CW) - 1 - TOL));
    for (int j = 0; j < WIN; j++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), base + CW'($urandom_range(0, TOL)));
  endtask

  task automatic bad_window();
    for (int j = 0; j < WIN; j++)
      step(1'b0, 1'b1, 1'(j % 2), (j % 2 == 1) ? 20'h80100 : 20'h80000);
  endtask

  // Phase error flips n times per window; ctrl jitters inside the band.
  task automatic flip_window(input int n);
    for (int j = 0; j < WIN; j++) begin
      if (j > 0 && (j % 10) == 0 && (j / 10) <= n) cur_pe = ~cur_pe;
      step(1'b0, 1'b1, cur_pe, 20'h80000 + CW'($urandom_range(0, TOL)));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_lost = 1'b0;
    m_done = 1'b0;
    model_clear(1'b0);
    rst = 1'b1;
    enable = 1'b0;
    phase_error = 1'b0;
    dig_ctrl_voltage = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CW'($urandom));
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_span", 32'(window_span), 32'd0);

    // Acquire with constant ctrl and phase error toggling each cycle
    for (int i = 0; i < LOCK_W * WIN; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 20'h80000);
      chk("acq_done_cadence", 32'(window_done), 32'((i % WIN) == WIN - 1));
      if (i == WIN - 1) chk("acq_w1_state", 32'(lock_state), 32'd1);
      if (i == (LOCK_W - 1) * WIN - 1) chk("acq_w7_state", 32'(lock_state), 32'd1);
    end
    chk("acq_locked", 32'(locked), 32'd1);
    chk("acq_state", 32'(lock_state), 32'd2);
    chk("acq_span", 32'(window_span), 32'd0);

    // Slewing control word never qualifies
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3 * WIN; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 20'h80000 + CW'(i));
      chk("slew_locked", 32'(locked), 32'd0);
      if ((i % WIN) == WIN - 1) begin
        chk("slew_span", 32'(window_span), 32'd255);
        chk("slew_state", 32'(lock_state), 32'd0);
      end
    end

    // Too little dither, then just enough
    step(1'b1, 1'b0, 1'b0, '0);
    cur_pe = 1'b1;
    flip_window(0);
    chk("nodither_state", 32'(lock_state), 32'd0);
    flip_window(3);
    chk("dither3_state", 32'(lock_state), 32'd0);
    flip_window(4);
    chk("dither4_state", 32'(lock_state), 32'd1);

    // Finish acquiring, then exercise loss of lock
    for (int w = 0; w < LOCK_W - 1; w++) good_window();
    chk("relock_locked", 32'(locked), 32'd1);
    bad_window();
    chk("one_bad_span", 32'(window_span), 32'd256);
    chk("one_bad_state", 32'(lock_state), 32'd2);
    good_window();
    chk("bad_good_state", 32'(lock_state), 32'd2);
    bad_window();
    chk("bad1_lost", 32'(lock_lost), 32'd0);
    bad_window();
    chk("bad2_lost", 32'(lock_lost), 32'd1);
    chk("bad2_locked", 32'(locked), 32'd0);
    chk("bad2_state", 32'(lock_state), 32'd0);
    step(1'b0, 1'b1, 1'b0, 20'h80000);
    chk("lost_pulse_width", 32'(lock_lost), 32'd0);

    // Reset mid-window while acquiring at good count 5
    step(1'b1, 1'b0, 1'b0, '0);
    for (int w = 0; w < 5; w++) good_window();
    chk("abort_pre_state", 32'(lock_state), 32'd1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'(i % 2), 20'h80000);
    step(1'b1, 1'b1, 1'b0, 20'h80000);
    chk("abort_rst_state", 32'(lock_state), 32'd0);
    for (int w = 0; w < LOCK_W - 1; w++) good_window();
    chk("reacq_w7_state", 32'(lock_state), 32'd1);
    good_window();
    chk("reacq_w8_state", 32'(lock_state), 32'd2);

    // Enable drop while locked: no loss pulse, span holds
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'(i % 2), 20'h80000);
    step(1'b0, 1'b0, 1'b0, 20'h80000);
    chk("endrop_locked", 32'(locked), 32'd0);
    chk("endrop_lost", 32'(lock_lost), 32'd0);

    // Enable drop mid-window while acquiring
    for (int w = 0; w < 3; w++) good_window();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'(i % 2), 20'h80000);
    step(1'b0, 1'b0, 1'b1, 20'h80000);
    chk("endrop_acq_state", 32'(lock_state), 32'd0);
    good_window();
    chk("endrop_fresh_state", 32'(lock_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
